// File: rtl/bp_update_sched_if.sv
// Resolved-branch update channel from writeback into the PHT/BHR update scheduler.
interface bp_update_sched_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_pc;
  logic [2:0]  upd_hist;
  logic        upd_taken;

  modport master (output upd_valid, upd_pc, upd_hist, upd_taken, input upd_ready);
  modport slave  (input upd_valid, upd_pc, upd_hist, upd_taken, output upd_ready);
endinterface

// File: rtl/bp_update_sched.sv
// Global predictor update scheduler: queues resolved branches, performs PHT
// read-modify-write of 2-bit counters, shifts the BHR and sweeps the PHT on reset/flush.
module bp_update_sched #(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bp_update_sched_if.slave     upd,
  input  logic                 flush_req,
  output logic [IDX_W-1:0]     pht_rd_index,
  input  logic [1:0]           pht_rd_state,
  output logic                 pht_we,
  output logic [IDX_W-1:0]     pht_wr_index,
  output logic [1:0]           pht_wr_data,
  output logic                 bhr_shift,
  output logic                 bhr_taken,
  output logic                 init_done,
  output logic                 busy
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_READ, ST_WRITE} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep_cnt;
  logic             flush_pend;
  logic [IDX_W-1:0] fifo_idx   [DEPTH];
  logic             fifo_taken [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             flush_now;
  logic             flush_apply;
  logic             enq;
  logic             pop;
  logic             fifo_empty;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [1:0]       ctr_next;
  logic             unused_pc;

  assign unused_pc     = ^{upd.upd_pc[15:6], upd.upd_pc[0]};
  assign upd_idx       = IDX_W'({upd.upd_pc[5:1], upd.upd_hist});
  assign head_idx      = fifo_idx[rd_ptr];
  assign head_taken    = fifo_taken[rd_ptr];
  assign fifo_empty    = (count == '0);
  assign upd.upd_ready = (count != CNT_W'(DEPTH));

  // A flush seen in READ is held until WRITE retires so PHT and BHR stay paired.
  assign flush_now   = flush_req | flush_pend;
  assign flush_apply = flush_now & (state != ST_READ);
  assign enq         = upd.upd_valid & upd.upd_ready & ~flush_apply;
  assign pop         = (state == ST_READ);
  assign busy        = (state != ST_IDLE) | ~fifo_empty;

  always_comb begin
    ctr_next = pht_rd_state;
    if (head_taken) begin
      if (pht_rd_state != 2'b11) ctr_next = pht_rd_state + 2'b01;
    end else begin
      if (pht_rd_state != 2'b00) ctr_next = pht_rd_state - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_idx[wr_ptr]   <= upd_idx;
      fifo_taken[wr_ptr] <= upd.upd_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      sweep_cnt    <= '0;
      flush_pend   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pht_rd_index <= '0;
      pht_we       <= 1'b0;
      pht_wr_index <= '0;
      pht_wr_data  <= INIT_STATE;
      bhr_shift    <= 1'b0;
      bhr_taken    <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      pht_we    <= 1'b0;
      bhr_shift <= 1'b0;
      if (flush_apply) begin
        state      <= ST_INIT;
        sweep_cnt  <= '0;
        flush_pend <= 1'b0;
        init_done  <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
      end else begin
        if (flush_req) flush_pend <= 1'b1;
        if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(pop);
        unique case (state)
          ST_INIT: begin
            pht_we       <= 1'b1;
            pht_wr_index <= sweep_cnt;
            pht_wr_data  <= INIT_STATE;
            sweep_cnt    <= sweep_cnt + IDX_W'(1);
            if (sweep_cnt == '1) state <= ST_IDLE;
          end
          ST_IDLE: begin
            init_done <= 1'b1;
            if (!fifo_empty) begin
              state        <= ST_READ;
              pht_rd_index <= head_idx;
            end
          end
          ST_READ: begin
            pht_we       <= 1'b1;
            pht_wr_index <= pht_rd_index;
            pht_wr_data  <= ctr_next;
            bhr_shift    <= 1'b1;
            bhr_taken    <= head_taken;
            state        <= ST_WRITE;
          end
          ST_WRITE: begin
            if (!fifo_empty) begin
              state        <= ST_READ;
              pht_rd_index <= head_idx;
            end else begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: PHT memory model, counter reference model, scenario tasks.
module tb_bp_update_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush_req = 1'b0;
  logic [7:0] pht_rd_index, pht_wr_index;
  logic [1:0] pht_rd_state, pht_wr_data;
  logic       pht_we, bhr_shift, bhr_taken, init_done, busy;

  bp_update_sched_if uif ();

  bp_update_sched #(.IDX_W(8), .DEPTH(4), .INIT_STATE(2'b01)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .upd          (uif.slave),
    .flush_req    (flush_req),
    .pht_rd_index (pht_rd_index),
    .pht_rd_state (pht_rd_state),
    .pht_we       (pht_we),
    .pht_wr_index (pht_wr_index),
    .pht_wr_data  (pht_wr_data),
    .bhr_shift    (bhr_shift),
    .bhr_taken    (bhr_taken),
    .init_done    (init_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [1:0] pht_mem [256];
  assign pht_rd_state = pht_mem[pht_rd_index];
  always @(posedge clk) if (pht_we) pht_mem[pht_wr_index] <= pht_wr_data;

  typedef struct { logic [7:0] idx; logic [1:0] data; logic taken; } exp_t;
  typedef struct { logic [7:0] idx; logic [1:0] data; logic taken; logic we; int cyc; } obs_t;

  exp_t       exp_q [$];
  obs_t       obs_q [$];
  logic [1:0] ref_pht [256];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  // Record every BHR-shift cycle as an observed update write.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bhr_shift) obs_q.push_back('{pht_wr_index, pht_wr_data, bhr_taken, pht_we, cyc});
  end

  // Reference: index from pc bits [5:1] and history, counter steps by +/-1 clamped to 0..3.
  function automatic void model_accept(input logic [15:0] pc, input logic [2:0] hist, input logic taken);
    int idx = ((int'(pc) / 2) % 32) * 8 + int'(hist);
    int v = int'(ref_pht[idx]) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    ref_pht[idx] = 2'(v);
    exp_q.push_back('{8'(idx), 2'(v), taken});
  endfunction

  function automatic void model_init();
    for (int i = 0; i < 256; i++) ref_pht[i] = 2'b01;
    exp_q.delete();
  endfunction

  task automatic drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic do_update(input logic [15:0] pc, input logic [2:0] hist, input logic taken);
    bit sent = 1'b0;
    for (int i = 0; i < 50 && !sent; i++) begin
      @(negedge clk);
      if (uif.upd_ready) begin
        uif.upd_pc = pc; uif.upd_hist = hist; uif.upd_taken = taken; uif.upd_valid = 1'b1;
        model_accept(pc, hist, taken);
        sent = 1'b1;
      end
    end
    @(negedge clk);
    uif.upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({uif.upd_ready, pht_we, bhr_shift, bhr_taken, init_done, busy} !== 6'b100001) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready,we,shift,taken,done,busy=%b expected 100001",
               {uif.upd_ready, pht_we, bhr_shift, bhr_taken, init_done, busy});
    end
    n_tests++;
    if ({pht_rd_index, pht_wr_index, pht_wr_data} !== {8'h00, 8'h00, 2'b01}) begin
      n_fail++;
      $display("FAIL reset_data: got rd=%h wr=%h data=%b expected rd=00 wr=00 data=01",
               pht_rd_index, pht_wr_index, pht_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pht_we !== 1'b1 || pht_wr_index !== 8'(i) || pht_wr_data !== 2'b01 || init_done !== 1'b0) begin
        if (bad == 0)
          $display("FAIL sweep[%0d]: got we=%b idx=%h data=%b done=%b expected we=1 idx=%h data=01 done=0",
                   i, pht_we, pht_wr_index, pht_wr_data, init_done, 8'(i));
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    @(negedge clk);
    n_tests++;
    if ({pht_we, init_done, busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL sweep_end: got we,done,busy=%b expected 010", {pht_we, init_done, busy});
    end
    model_init();
    obs_q.delete();
  endtask

  task automatic test_single();
    bit ok;
    @(negedge clk);
    uif.upd_pc = 16'h0012; uif.upd_hist = 3'b101; uif.upd_taken = 1'b1; uif.upd_valid = 1'b1;
    model_accept(16'h0012, 3'b101, 1'b1);
    @(negedge clk);
    uif.upd_valid = 1'b0;
    n_tests++;
    if ({pht_we, bhr_shift} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_early: got we,shift=%b expected 00", {pht_we, bhr_shift});
    end
    @(negedge clk);
    n_tests++;
    if (pht_rd_index !== 8'h4D) begin
      n_fail++;
      $display("FAIL single_read: got rd_index=%h expected 4d", pht_rd_index);
    end
    @(negedge clk);
    n_tests++;
    if ({pht_we, pht_wr_index, pht_wr_data, bhr_shift, bhr_taken} !== {1'b1, 8'h4D, 2'b10, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_write: got we=%b idx=%h data=%b shift=%b taken=%b expected we=1 idx=4d data=10 shift=1 taken=1",
               pht_we, pht_wr_index, pht_wr_data, bhr_shift, bhr_taken);
    end
    drain(20, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_drain: busy=%b expected 0 within bound", busy); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_saturation();
    bit ok;
    repeat (3) do_update(16'h0020, 3'd0, 1'b1);
    repeat (2) do_update(16'h0022, 3'd1, 1'b0);
    drain(30, ok);
    n_tests++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sat_count: got %0d writes (drained=%0d) expected %0d", obs_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].we !== 1'b1 || obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].taken !== exp_q[i].taken) begin
        n_fail++;
        $display("FAIL sat_wr[%0d]: got we=%b idx=%h data=%b taken=%b expected we=1 idx=%h data=%b taken=%b",
                 i, obs_q[i].we, obs_q[i].idx, obs_q[i].data, obs_q[i].taken,
                 exp_q[i].idx, exp_q[i].data, exp_q[i].taken);
      end
    end
    if (obs_q.size() == 5) begin
      n_tests++;
      if (obs_q[2].data !== 2'b11 || obs_q[4].data !== 2'b00) begin
        n_fail++;
        $display("FAIL sat_bounds: got top=%b bottom=%b expected top=11 bottom=00", obs_q[2].data, obs_q[4].data);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [1:0] want [3];
    want[0] = 2'b10; want[1] = 2'b11; want[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      uif.upd_pc = 16'h0030; uif.upd_hist = 3'd2; uif.upd_taken = 1'b1; uif.upd_valid = 1'b1;
      if (uif.upd_ready) model_accept(16'h0030, 3'd2, 1'b1);
    end
    @(negedge clk);
    uif.upd_valid = 1'b0;
    drain(30, ok);
    n_tests++;
    if (!ok || obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes (drained=%0d) expected 3", obs_q.size(), ok);
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].idx !== 8'd194 || obs_q[i].data !== want[i] || obs_q[i].we !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_wr[%0d]: got we=%b idx=%h data=%b expected we=1 idx=c2 data=%b",
                 i, obs_q[i].we, obs_q[i].idx, obs_q[i].data, want[i]);
      end
      if (i > 0) begin
        n_tests++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != 2) begin
          n_fail++;
          $display("FAIL b2b_gap[%0d]: got %0d cycles expected 2", i, obs_q[i].cyc - obs_q[i-1].cyc);
        end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit acc = 1'b0;
    logic [15:0] pcs [5];
    logic [2:0]  hs [5];
    logic        ts [5];
    logic [4:0]  rdy;
    for (int k = 0; k < 5; k++) begin
      pcs[k] = 16'($urandom); hs[k] = 3'($urandom); ts[k] = 1'($urandom);
    end
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    model_init();
    n_tests++;
    if (init_done !== 1'b0) begin n_fail++; $display("FAIL full_flush: got init_done=%b expected 0", init_done); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      uif.upd_pc = pcs[k]; uif.upd_hist = hs[k]; uif.upd_taken = ts[k]; uif.upd_valid = 1'b1;
      rdy[k] = uif.upd_ready;
      if (uif.upd_ready) model_accept(pcs[k], hs[k], ts[k]);
    end
    n_tests++;
    if (rdy !== 5'b01111) begin
      n_fail++;
      $display("FAIL full_ready: got ready history (slot4..0)=%b expected 01111", rdy);
    end
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (uif.upd_ready) begin model_accept(pcs[4], hs[4], ts[4]); acc = 1'b1; end
    end
    n_tests++;
    if (!acc) begin n_fail++; $display("FAIL full_accept5: got ready=0 for 400 cycles expected 1"); end
    @(negedge clk);
    uif.upd_valid = 1'b0;
    drain(100, ok);
    n_tests++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL full_count: got %0d writes (drained=%0d) expected %0d", obs_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].we !== 1'b1 || obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].taken !== exp_q[i].taken) begin
        n_fail++;
        $display("FAIL full_wr[%0d]: got we=%b idx=%h data=%b taken=%b expected we=1 idx=%h data=%b taken=%b",
                 i, obs_q[i].we, obs_q[i].idx, obs_q[i].data, obs_q[i].taken,
                 exp_q[i].idx, exp_q[i].data, exp_q[i].taken);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_flush_read();
    int bad = 0;
    bit found = 1'b0;
    exp_t a;
    @(negedge clk);
    uif.upd_pc = 16'h003A; uif.upd_hist = 3'd6; uif.upd_taken = 1'b0; uif.upd_valid = 1'b1;
    model_accept(16'h003A, 3'd6, 1'b0);
    a = exp_q[0];
    @(negedge clk);
    uif.upd_pc = 16'h0004; uif.upd_hist = 3'd3; uif.upd_taken = 1'b1;
    @(negedge clk);
    uif.upd_valid = 1'b0; flush_req = 1'b1;
    n_tests++;
    if (pht_rd_index !== a.idx) begin
      n_fail++; $display("FAIL flush_read: got rd_index=%h expected %h", pht_rd_index, a.idx);
    end
    @(negedge clk);
    flush_req = 1'b0;
    n_tests++;
    if ({pht_we, bhr_shift, pht_wr_index, pht_wr_data, bhr_taken} !== {1'b1, 1'b1, a.idx, a.data, a.taken}) begin
      n_fail++;
      $display("FAIL flush_write: got we=%b shift=%b idx=%h data=%b taken=%b expected we=1 shift=1 idx=%h data=%b taken=%b",
               pht_we, bhr_shift, pht_wr_index, pht_wr_data, bhr_taken, a.idx, a.data, a.taken);
    end
    @(negedge clk);
    n_tests++;
    if ({pht_we, init_done} !== 2'b00) begin
      n_fail++; $display("FAIL flush_enter: got we,done=%b expected 00", {pht_we, init_done});
    end
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (pht_we === 1'b1) found = 1'b1;
    end
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      if (!found || pht_we !== 1'b1 || pht_wr_index !== 8'(i) || pht_wr_data !== 2'b01 || init_done !== 1'b0) begin
        if (bad == 0)
          $display("FAIL flush_sweep[%0d]: got we=%b idx=%h data=%b done=%b expected we=1 idx=%h data=01 done=0",
                   i, pht_we, pht_wr_index, pht_wr_data, init_done, 8'(i));
        bad++;
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
    @(negedge clk);
    n_tests++;
    if ({init_done, busy} !== 2'b10) begin
      n_fail++; $display("FAIL flush_done: got done,busy=%b expected 10", {init_done, busy});
    end
    #1;
    n_tests++;
    if (obs_q.size() != 1) begin
      n_fail++; $display("FAIL flush_discard: got %0d update writes expected 1", obs_q.size());
    end
    model_init();
    obs_q.delete();
  endtask

  task automatic test_reset_mid_sweep();
    bit ok = 1'b0;
    @(negedge clk); flush_req = 1'b1;
    @(negedge clk); flush_req = 1'b0;
    repeat (100) @(negedge clk);
    n_tests++;
    if (pht_we !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got we=%b expected 1", pht_we); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pht_we, init_done, busy, uif.upd_ready, bhr_shift} !== 5'b00110) begin
      n_fail++;
      $display("FAIL midrst_async: got we,done,busy,ready,shift=%b expected 00110",
               {pht_we, init_done, busy, uif.upd_ready, bhr_shift});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({pht_we, pht_wr_index} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL midrst_restart: got we=%b idx=%h expected we=1 idx=00", pht_we, pht_wr_index);
    end
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (init_done === 1'b1) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL midrst_done: got init_done=0 after 300 cycles expected 1"); end
    model_init();
    obs_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    logic [15:0] pc;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      uif.upd_valid = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        pc = 16'($urandom);
        pc[5:1] = 5'($urandom_range(0, 3));
        uif.upd_pc = pc; uif.upd_hist = 3'($urandom_range(0, 1)); uif.upd_taken = 1'($urandom);
        uif.upd_valid = 1'b1;
        if (uif.upd_ready) model_accept(uif.upd_pc, uif.upd_hist, uif.upd_taken);
      end
    end
    @(negedge clk);
    uif.upd_valid = 1'b0;
    drain(100, ok);
    n_tests++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d writes (drained=%0d) expected %0d", obs_q.size(), ok, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++;
      if (obs_q[i].we !== 1'b1 || obs_q[i].idx !== exp_q[i].idx || obs_q[i].data !== exp_q[i].data ||
          obs_q[i].taken !== exp_q[i].taken) begin
        n_fail++;
        $display("FAIL rand_wr[%0d]: got we=%b idx=%h data=%b taken=%b expected we=1 idx=%h data=%b taken=%b",
                 i, obs_q[i].we, obs_q[i].idx, obs_q[i].data, obs_q[i].taken,
                 exp_q[i].idx, exp_q[i].data, exp_q[i].taken);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    uif.upd_valid = 1'b0;
    uif.upd_pc    = '0;
    uif.upd_hist  = '0;
    uif.upd_taken = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_back_to_back();
    test_fifo_full();
    test_flush_read();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
